// File: rtl/fifo_unpacker_pkg.sv
// ============================================================================
// Module      : fifo_unpacker_pkg
// Description : Shared beat-order encodings, unpacker states and the
//               width-ratio legality check used by the unpacker and packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_unpacker_pkg;

  localparam int c_LSB_FIRST = 0;
  localparam int c_MSB_FIRST = 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // A wide word must split into a whole number of beats, and at least two.
  function automatic bit ratio_legal(input int dwidth, input int owidth);
    if (owidth <= 0) return 1'b0;
    return ((dwidth % owidth) == 0) && ((dwidth / owidth) >= 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_unpacker.sv
// ============================================================================
// Module      : fifo_unpacker
// Description : Pops wide words from a FWFT FIFO and emits them as RATIO
//               narrow valid/ready beats, back to back with no bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_unpacker
  import fifo_unpacker_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int OWIDTH    = 8,
  parameter int RATIO     = DWIDTH / OWIDTH,
  parameter int CWIDTH    = $clog2(RATIO),
  parameter int MSB_FIRST = c_LSB_FIRST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_read,
  output logic [OWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  if (!ratio_legal(DWIDTH, OWIDTH) || (RATIO != DWIDTH / OWIDTH)) begin : g_bad_ratio
    $error("fifo_unpacker: DWIDTH must be a multiple (>= 2x) of OWIDTH");
  end

  state_e              r_state;
  state_e              w_state_next;
  logic [DWIDTH-1:0]   r_shift;
  logic [DWIDTH-1:0]   w_shift_next;
  logic [DWIDTH-1:0]   w_shifted;
  logic [CWIDTH-1:0]   r_cnt;
  logic [CWIDTH-1:0]   w_cnt_next;
  logic                w_acc;
  logic                w_last;

  // The output slice sits at one end of the shift register; each accepted
  // beat moves the next slice into it.
  if (MSB_FIRST == c_MSB_FIRST) begin : g_msb_first
    assign w_shifted = {r_shift[DWIDTH-OWIDTH-1:0], {OWIDTH{1'b0}}};
    assign out_data  = r_shift[DWIDTH-1 -: OWIDTH];
  end else begin : g_lsb_first
    assign w_shifted = {{OWIDTH{1'b0}}, r_shift[DWIDTH-1:OWIDTH]};
    assign out_data  = r_shift[OWIDTH-1:0];
  end

  assign out_valid = (r_state == ST_STREAM);
  assign w_acc     = out_valid & out_ready;
  assign w_last    = (r_cnt == CWIDTH'(RATIO - 1)) & (r_state == ST_STREAM);
  assign out_last  = w_last;

  // Reloading on the last accepted beat keeps the stream gap-free.
  assign fifo_read = !rst && !fifo_empty &&
                     ((r_state == ST_IDLE) || (w_acc && w_last));

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_cnt_next   = r_cnt;
    if (fifo_read) begin
      w_state_next = ST_STREAM;
      w_shift_next = fifo_dout;
      w_cnt_next   = '0;
    end else if (w_acc) begin
      if (w_last) begin
        w_state_next = ST_IDLE;
      end else begin
        w_shift_next = w_shifted;
        w_cnt_next   = r_cnt + CWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_cnt   <= w_cnt_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_unpacker.sv
// ============================================================================
// Module      : tb_fifo_unpacker
// Description : Bench for fifo_unpacker: a small FWFT FIFO model feeds an
//               LSB-first and an MSB-first instance; beats are scoreboarded.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_unpacker;
  import fifo_unpacker_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic [31:0] word;
    logic        msb;
    logic [31:0] exp_seq;  // beat i expected in bits [8*i +: 8]
  } vec_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fifo_rst, sel, out_ready, wr_en;
  logic [31:0] wr_data;

  // FWFT FIFO model, depth 4
  logic [31:0] mem [4];
  logic [1:0]  wp, rp;
  logic [2:0]  cnt;
  logic        fifo_empty, pop, w_wr, w_rd;
  logic [31:0] fifo_dout;

  logic        empty_a, empty_b, read_a, read_b, valid_a, valid_b, last_a, last_b;
  logic [7:0]  data_a, data_b;
  logic        act_valid, act_last, act_read;
  logic [7:0]  act_data;

  beat_t       exp_q[$];
  int          acc_log[$];
  int          cyc   = 0;
  int          pops  = 0;
  int          total = 0;
  int          bad   = 0;

  assign fifo_empty = (cnt == 3'd0);
  assign fifo_dout  = mem[rp];
  assign empty_a    = sel ? 1'b1 : fifo_empty;
  assign empty_b    = sel ? fifo_empty : 1'b1;
  assign pop        = sel ? read_b : read_a;
  assign w_wr       = wr_en && (cnt != 3'd4);
  assign w_rd       = pop && (cnt != 3'd0);
  assign act_valid  = sel ? valid_b : valid_a;
  assign act_last   = sel ? last_b  : last_a;
  assign act_data   = sel ? data_b  : data_a;
  assign act_read   = sel ? read_b  : read_a;

  always_ff @(posedge clk) begin
    if (fifo_rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (w_wr) begin
        mem[wp] <= wr_data;
        wp      <= wp + 2'd1;
      end
      if (w_rd) rp <= rp + 2'd1;
      cnt <= cnt + {2'b00, w_wr} - {2'b00, w_rd};
    end
  end

  fifo_unpacker #(.DWIDTH(32), .OWIDTH(8), .MSB_FIRST(c_LSB_FIRST)) u_lsb (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(empty_a),
    .fifo_read(read_a), .out_data(data_a), .out_valid(valid_a),
    .out_ready(out_ready), .out_last(last_a)
  );

  fifo_unpacker #(.DWIDTH(32), .OWIDTH(8), .MSB_FIRST(c_MSB_FIRST)) u_msb (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(empty_b),
    .fifo_read(read_b), .out_data(data_b), .out_valid(valid_b),
    .out_ready(out_ready), .out_last(last_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] order_beats(input logic [31:0] w, input logic msb);
    return msb ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
  endfunction

  task automatic push_word(input logic [31:0] exp_seq);
    for (int i = 0; i < 4; i++) exp_q.push_back({exp_seq[8*i +: 8], (i == 3)});
  endtask

  task automatic write_word(input logic [31:0] w, input logic [31:0] exp_seq);
    wr_en   = 1'b1;
    wr_data = w;
    push_word(exp_seq);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic write2(input logic [31:0] a, input logic [31:0] b);
    wr_en   = 1'b1;
    wr_data = a;
    push_word(order_beats(a, 1'b0));
    @(posedge clk); #1;
    wr_data = b;
    push_word(order_beats(b, 1'b0));
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: got %0d beats outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every accepted beat is compared against the queue head.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && act_valid && out_ready) begin
      acc_log.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got 0x%0h expected none", act_data);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", {24'd0, act_data}, {24'd0, e.data});
        chk("beat_last", {31'd0, act_last}, {31'd0, e.last});
      end
    end
    if (act_read && act_valid)
      chk("pop_with_last_acc", {30'd0, out_ready, act_last}, 32'd3);
    if (act_read) pops++;
  end

  vec_t vecs[5];

  initial begin
    int   pops0;
    logic found;

    vecs[0] = '{word: 32'hAABBCCDD, msb: 1'b0, exp_seq: 32'hAABBCCDD};
    vecs[1] = '{word: 32'hAABBCCDD, msb: 1'b1, exp_seq: 32'hDDCCBBAA};
    vecs[2] = '{word: 32'h12345678, msb: 1'b1, exp_seq: 32'h78563412};
    vecs[3] = '{word: 32'hFFFF0000, msb: 1'b0, exp_seq: 32'hFFFF0000};
    vecs[4] = '{word: 32'h80000001, msb: 1'b1, exp_seq: 32'h01000080};

    rst = 1'b1; fifo_rst = 1'b1; sel = 1'b0; out_ready = 1'b1;
    wr_en = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1 fifo_rst = 1'b0;

    // Reset held with a non-empty FIFO: nothing popped, outputs quiet
    write_word(32'hA1B2C3D4, 32'hA1B2C3D4);
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", {31'd0, valid_a}, 32'd0);
      chk("rst_read",  {31'd0, read_a},  32'd0);
      chk("rst_data",  {24'd0, data_a},  32'd0);
      chk("rst_fifo_count", {29'd0, cnt}, 32'd1);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    wait_drain("after_reset");

    // Single word: pop strobe, one-cycle latency, idle afterwards
    pops0 = pops;
    write_word(32'hAABBCCDD, 32'hAABBCCDD);
    @(negedge clk);
    chk("lat_read",  {31'd0, read_a},  32'd1);
    chk("lat_valid", {31'd0, valid_a}, 32'd0);
    @(negedge clk);
    chk("lat_beat0_valid", {31'd0, valid_a}, 32'd1);
    chk("lat_beat0_data",  {24'd0, data_a},  32'hDD);
    wait_drain("single");
    @(negedge clk);
    chk("single_idle_valid", {31'd0, valid_a}, 32'd0);
    chk("single_pop_count", pops - pops0, 32'd1);
    @(posedge clk); #1;

    // Back-to-back words: eight beats on eight consecutive cycles
    acc_log.delete();
    write2(32'h03020100, 32'h07060504);
    wait_drain("b2b");
    chk("b2b_beats", acc_log.size(), 32'd8);
    if (acc_log.size() == 8) chk("b2b_span", acc_log[7] - acc_log[0], 32'd7);

    // Backpressure while 0xBB is presented
    write_word(32'hAABBCCDD, 32'hAABBCCDD);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (valid_a && data_a == 8'hBB) found = 1'b1;
    end
    chk("bp_found_bb", {31'd0, found}, 32'd1);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_data",  {24'd0, data_a},  32'hBB);
      chk("bp_valid", {31'd0, valid_a}, 32'd1);
      chk("bp_last",  {31'd0, last_a},  32'd0);
      chk("bp_read",  {31'd0, read_a},  32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_drain("bp");

    // Table of single words across both beat orders
    foreach (vecs[k]) begin
      sel = vecs[k].msb;
      write_word(vecs[k].word, vecs[k].exp_seq);
      wait_drain("vec");
      @(negedge clk);
      chk("vec_idle", {31'd0, act_valid}, 32'd0);
      @(posedge clk); #1;
    end
    sel = 1'b0;

    // Reset mid-word with a second word queued
    write2(32'h11223344, 32'h55667788);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (valid_a && data_a == 8'h22) found = 1'b1;
    end
    chk("mid_found_22", {31'd0, found}, 32'd1);
    rst = 1'b1; fifo_rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; fifo_rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, valid_a}, 32'd0);
    chk("mid_rst_empty", {31'd0, fifo_empty}, 32'd1);
    chk("mid_rst_data",  {24'd0, data_a}, 32'd0);
    @(posedge clk); #1;
    write_word(32'h99AABBCC, 32'h99AABBCC);
    wait_drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
